multiword_add_seq: RTL

MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

---
 rtl/multiword_add_seq_if.sv | 32 +++
 rtl/multiword_add_seq.sv | 133 +++++++++++++
 2 files changed

// File: rtl/multiword_add_seq_if.sv
// Request/response bundle for the word-serial multiword adder/subtractor.
// The master issues operands and consumes the result; the slave is the adder.
interface multiword_add_seq_if #(
    parameter int unsigned NW = 4
);
    localparam int unsigned DATA_W = 16 * NW;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              sub;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              sign;
    logic              carry;
    logic              overflow;
    logic              parity;
    logic              zero;
    logic              busy;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, sign, carry, overflow, parity, zero, busy
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, sign, carry, overflow, parity, zero, busy
    );
endinterface

// File: rtl/multiword_add_seq.sv
// Word-serial NW x 16-bit adder/subtractor: one shared 16-bit slice walks the
// operands LSW to MSW, then holds result and flags until the consumer takes them.
module multiword_add_seq #(
    parameter int unsigned NW = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multiword_add_seq_if.slave    bus
);
    localparam int unsigned WORD_W = 16;
    localparam int unsigned DATA_W = WORD_W * NW;
    localparam int unsigned IDX_W  = $clog2(NW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               c_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic               sub_q;
    logic [DATA_W-1:0]  result_q;
    logic               sign_q;
    logic               carry_q;
    logic               overflow_q;
    logic               parity_q;
    logic               zero_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [WORD_W-1:0]  a_word;
    logic [WORD_W-1:0]  b_eff;
    logic [WORD_W:0]    slice;
    logic [DATA_W-1:0]  result_next;
    logic               last_word;
    logic               msb_a;
    logic               msb_b_eff;
    logic               msb_res;

    // The single adder slice, steered by the current word index
    always_comb begin
        a_word      = a_q[WORD_W * 32'(idx_q) +: WORD_W];
        b_eff       = b_q[WORD_W * 32'(idx_q) +: WORD_W] ^ {WORD_W{sub_q}};
        slice       = (WORD_W+1)'(a_word) + (WORD_W+1)'(b_eff) + (WORD_W+1)'(c_q);
        result_next = result_q;
        result_next[WORD_W * 32'(idx_q) +: WORD_W] = slice[WORD_W-1:0];
        last_word   = (idx_q == IDX_W'(NW - 1));
        msb_a       = a_q[DATA_W-1];
        msb_b_eff   = b_q[DATA_W-1] ^ sub_q;
        msb_res     = result_next[DATA_W-1];
    end

    // Control FSM with registered handshake outputs and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            c_q         <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            result_q    <= '0;
            sign_q      <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            parity_q    <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        sub_q      <= bus.sub;
                        c_q        <= bus.sub;
                        idx_q      <= '0;
                        state_q    <= EXEC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                EXEC: begin
                    result_q <= result_next;
                    c_q      <= slice[WORD_W];
                    if (last_word) begin
                        carry_q     <= slice[WORD_W];
                        sign_q      <= msb_res;
                        // Like-signed operands producing an opposite-signed result
                        overflow_q  <= (msb_a == msb_b_eff) && (msb_res != msb_a);
                        parity_q    <= ~^result_next;
                        zero_q      <= ~|result_next;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = result_q;
    assign bus.sign      = sign_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.parity    = parity_q;
    assign bus.zero      = zero_q;
endmodule
